// File: rtl/phy_pkg.sv
// phy_pkg: receive-FSM state encoding and the idle comma shared with the transmit serializer.
package phy_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [7:0] IDLE_BYTE = 8'hBC;

endpackage

// File: rtl/comma_detect.sv
// comma_detect: MSB-first 8-bit shift register with a compare against the idle comma.
module comma_detect
    import phy_pkg::*;
#(
    parameter logic [7:0] IDLE = IDLE_BYTE
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       bit_i,
    output logic [7:0] sr_o,
    output logic       match_o
);

    logic [7:0] sr_q;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) sr_q <= 8'd0;
        else          sr_q <= {sr_q[6:0], bit_i};
    end

    assign sr_o    = sr_q;
    assign match_o = sr_q == IDLE;

endmodule

// File: rtl/serialtoparallel.sv
// serialtoparallel: comma-aligned serial-to-byte receiver with lock FSM.
// Define SERTOPAR_RELOCK_EN to drop lock after BC_LOCK misaligned commas.
module serialtoparallel
    import phy_pkg::*;
#(
    parameter int unsigned BC_LOCK = 4,
    parameter logic [7:0]  IDLE    = IDLE_BYTE
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

    logic [7:0] sr;
    logic       match;
    logic       boundary;
    logic       lock_loss;
    state_e     state_q, state_d;
    logic [2:0] ph_q, ph_d;
    logic [3:0] bc_q, bc_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q;
`ifdef SERTOPAR_RELOCK_EN
    logic [3:0] mis_q, mis_d;
`endif

    comma_detect #(.IDLE(IDLE)) u_comma (
        .clk_8f (clk_8f),
        .reset_L(reset_L),
        .bit_i  (data_in),
        .sr_o   (sr),
        .match_o(match)
    );

    assign boundary = ph_q == 3'd7;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q + 3'd1;
        bc_d      = bc_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        lock_loss = 1'b0;
`ifdef SERTOPAR_RELOCK_EN
        mis_d = mis_q;
        if (state_q == LOCKED && match) mis_d = boundary ? 4'd0 : mis_q + 4'd1;
        lock_loss = state_q == LOCKED && mis_d == LOCK_N;
        if (lock_loss) mis_d = 4'd0;
`endif
        case (state_q)
            SEARCH: begin
                ph_d = 3'd0;
                if (match) begin
                    bc_d    = 4'd1;
                    state_d = (LOCK_N == 4'd1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: if (boundary) begin
                bc_d    = match ? bc_q + 4'd1 : 4'd0;
                state_d = !match ? SEARCH : (bc_q + 4'd1 == LOCK_N) ? LOCKED : ALIGN;
            end
            // lock loss wins over a coincident data boundary
            LOCKED: if (lock_loss) begin
                state_d = SEARCH;
                bc_d    = 4'd0;
            end else if (boundary && !match) begin
                data_d  = sr;
                valid_d = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= SEARCH;
            ph_q     <= 3'd0;
            bc_q     <= 4'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
`ifdef SERTOPAR_RELOCK_EN
            mis_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            bc_q     <= bc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= state_d == LOCKED;
`ifdef SERTOPAR_RELOCK_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serialtoparallel.sv
// tb_serialtoparallel: directed scenarios for lock, alignment, idle filtering, reset and relock.
module tb_serialtoparallel;

    logic       clk_8f  = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    int         scyc[$];
    logic [7:0] sdat[$];
    int         rise[$];
    int         fall[$];
    logic       act_prev = 1'b0;

    always #5 clk_8f = ~clk_8f;

    serialtoparallel dut (
        .clk_8f   (clk_8f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // one bit per edge; outputs sampled 1 time unit after the edge, cyc = edges since release
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        cyc++;
        #1;
        if (valid_out) begin
            scyc.push_back(cyc);
            sdat.push_back(data_out);
        end
        if (active && !act_prev) rise.push_back(cyc);
        if (!active && act_prev) fall.push_back(cyc);
        act_prev = active;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start();
        reset_L = 1'b0;
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        reset_L = 1'b1;
        cyc = 0;
        scyc.delete();
        sdat.delete();
        rise.delete();
        fall.delete();
        act_prev = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            n_chk++;
            if ({data_out, valid_out, active} !== 10'd0)
                $display("FAIL reset_hold[%0d]: got data=%h valid=%b active=%b, want 0/0/0", i, data_out, valid_out, active);
            else n_pass++;
        end
        reset_L = 1'b1;
        cyc = 0;
        scyc.delete();
        repeat (24) send_bit(1'($urandom_range(0, 1)));
        n_chk++;
        if (scyc.size() != 0) $display("FAIL reset_no_strobe: got %0d strobes, want 0", scyc.size());
        else n_pass++;
        n_chk++;
        if (active !== 1'b0) $display("FAIL reset_no_lock: got active=%b, want 0", active);
        else n_pass++;
    endtask

    task automatic test_lock_aligned();
        int r0, c0, c1;
        logic [7:0] d0, d1;
        start();
        repeat (4) send_byte(8'hBC);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hBC);
        r0 = rise.size() > 0 ? rise[0] : -1;
        c0 = scyc.size() > 0 ? scyc[0] : -1;
        c1 = scyc.size() > 1 ? scyc[1] : -1;
        d0 = sdat.size() > 0 ? sdat[0] : 8'hxx;
        d1 = sdat.size() > 1 ? sdat[1] : 8'hxx;
        n_chk++;
        if (r0 != 33) $display("FAIL aligned_lock_cycle: got %0d, want 33", r0);
        else n_pass++;
        n_chk++;
        if (scyc.size() != 2) $display("FAIL aligned_strobe_count: got %0d, want 2", scyc.size());
        else n_pass++;
        n_chk++;
        if (c0 != 41 || d0 !== 8'hA5) $display("FAIL aligned_first: got cyc %0d data %h, want 41 a5", c0, d0);
        else n_pass++;
        n_chk++;
        if (c1 != 49 || d1 !== 8'h3C) $display("FAIL aligned_second: got cyc %0d data %h, want 49 3c", c1, d1);
        else n_pass++;
    endtask

    task automatic test_lock_unaligned();
        int r0, c0;
        logic [7:0] d0;
        start();
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        repeat (4) send_byte(8'hBC);
        send_byte(8'h5A);
        repeat (2) send_byte(8'hBC);
        r0 = rise.size() > 0 ? rise[0] : -1;
        c0 = scyc.size() > 0 ? scyc[0] : -1;
        d0 = sdat.size() > 0 ? sdat[0] : 8'hxx;
        n_chk++;
        if (r0 != 36) $display("FAIL unaligned_lock_cycle: got %0d, want 36", r0);
        else n_pass++;
        n_chk++;
        if (scyc.size() != 1) $display("FAIL unaligned_strobe_count: got %0d, want 1", scyc.size());
        else n_pass++;
        n_chk++;
        if (c0 != 44 || d0 !== 8'h5A) $display("FAIL unaligned_data: got cyc %0d data %h, want 44 5a", c0, d0);
        else n_pass++;
    endtask

    task automatic test_broken_lockup();
        int r0, c0;
        logic [7:0] d0;
        start();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h11);
        n_chk++;
        if (active !== 1'b0 || scyc.size() != 0)
            $display("FAIL broken_after_11: got active=%b strobes=%0d, want 0 0", active, scyc.size());
        else n_pass++;
        repeat (4) send_byte(8'hBC);
        send_byte(8'h42);
        send_byte(8'hBC);
        r0 = rise.size() > 0 ? rise[0] : -1;
        c0 = scyc.size() > 0 ? scyc[0] : -1;
        d0 = sdat.size() > 0 ? sdat[0] : 8'hxx;
        n_chk++;
        if (r0 != 57) $display("FAIL broken_lock_cycle: got %0d, want 57", r0);
        else n_pass++;
        n_chk++;
        if (scyc.size() != 1 || c0 != 65 || d0 !== 8'h42)
            $display("FAIL broken_strobe: got n=%0d cyc %0d data %h, want 1 65 42", scyc.size(), c0, d0);
        else n_pass++;
    endtask

    task automatic test_idle_filter();
        int gap;
        logic [7:0] d0, d1;
        start();
        repeat (4) send_byte(8'hBC);
        send_byte(8'h77);
        send_byte(8'hBC);
        n_chk++;
        if (data_out !== 8'h77 || valid_out !== 1'b0)
            $display("FAIL idle_hold1: got data=%h valid=%b, want 77 0", data_out, valid_out);
        else n_pass++;
        send_byte(8'hBC);
        n_chk++;
        if (data_out !== 8'h77 || scyc.size() != 1)
            $display("FAIL idle_hold2: got data=%h strobes=%0d, want 77 1", data_out, scyc.size());
        else n_pass++;
        send_byte(8'h88);
        send_byte(8'hBC);
        gap = scyc.size() > 1 ? scyc[1] - scyc[0] : -1;
        d0  = sdat.size() > 0 ? sdat[0] : 8'hxx;
        d1  = sdat.size() > 1 ? sdat[1] : 8'hxx;
        n_chk++;
        if (scyc.size() != 2 || gap != 24)
            $display("FAIL idle_spacing: got n=%0d gap=%0d, want 2 24", scyc.size(), gap);
        else n_pass++;
        n_chk++;
        if (d0 !== 8'h77 || d1 !== 8'h88) $display("FAIL idle_data: got %h %h, want 77 88", d0, d1);
        else n_pass++;
    endtask

    task automatic test_reset_locked();
        start();
        repeat (4) send_byte(8'hBC);
        send_byte(8'hA5);
        send_bit(1'b1);
        n_chk++;
        if (valid_out !== 1'b1 || data_out !== 8'hA5)
            $display("FAIL rst_locked_pre: got valid=%b data=%h, want 1 a5", valid_out, data_out);
        else n_pass++;
        #1 reset_L = 1'b0;
        #1;
        n_chk++;
        if ({data_out, valid_out, active} !== 10'd0)
            $display("FAIL rst_locked_clear: got data=%h valid=%b active=%b, want 0/0/0", data_out, valid_out, active);
        else n_pass++;
    endtask

    task automatic test_relock();
        start();
        repeat (4) send_byte(8'hBC);
        send_bit(1'b0);
        repeat (8) send_byte(8'hBC);
        send_byte(8'h5A);
        repeat (2) send_byte(8'hBC);
`ifdef SERTOPAR_RELOCK_EN
        begin
            int f0, r1, cl;
            logic [7:0] dl;
            f0 = fall.size() > 0 ? fall[0] : -1;
            r1 = rise.size() > 1 ? rise[1] : -1;
            cl = scyc.size() > 0 ? scyc[$] : -1;
            dl = sdat.size() > 0 ? sdat[$] : 8'hxx;
            n_chk++;
            if (fall.size() != 1 || f0 != 66) $display("FAIL relock_drop: got n=%0d cyc %0d, want 1 66", fall.size(), f0);
            else n_pass++;
            n_chk++;
            if (rise.size() != 2 || r1 != 98) $display("FAIL relock_rise: got n=%0d cyc %0d, want 2 98", rise.size(), r1);
            else n_pass++;
            n_chk++;
            if (scyc.size() != 5 || cl != 106 || dl !== 8'h5A)
                $display("FAIL relock_data: got n=%0d cyc %0d data %h, want 5 106 5a", scyc.size(), cl, dl);
            else n_pass++;
        end
`else
        n_chk++;
        if (fall.size() != 0 || active !== 1'b1)
            $display("FAIL nolock_drop: got falls=%0d active=%b, want 0 1", fall.size(), active);
        else n_pass++;
        n_chk++;
        if (rise.size() != 1) $display("FAIL nolock_rise: got %0d rises, want 1", rise.size());
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_lock_aligned();
        test_lock_unaligned();
        test_broken_lockup();
        test_idle_filter();
        test_reset_locked();
        test_relock();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serialtoparallel.md
# serialtoparallel

Serial-to-parallel receiver for the PHY link. It samples the 1-bit serial stream at `clk_8f`, finds byte alignment from the idle comma `0xBC`, and locks after a configurable run of aligned commas. Once locked, it delivers each non-idle byte as an 8-bit word with a one-cycle valid strobe. It sits at the receive end of the lane and feeds the unstriping/byte-merge logic.

## Interface
- `BC_LOCK`, default 4: consecutive byte-aligned `0xBC` commas needed to declare lock (legal range 1..15).
- `IDLE`, default 8'hBC: idle/comma byte.
- `clk_8f` in 1: bit clock; one serial bit sampled per rising edge.
- `reset_L` in 1: reset, asynchronous, active-low.
- `data_in` in 1: serial bit, MSB of each byte first.
- `data_out` out 8: last received non-idle byte; held between strobes.
- `valid_out` out 1: one-cycle strobe, `data_out` updated this cycle.
- `active` out 1: high while in LOCKED.

## Operation
- Shift register `sr[7:0]` updates every cycle: `sr <= {sr[6:0], data_in}`.
- `match = (sr == IDLE)` is evaluated on the current registered `sr`.
- Phase counter `ph[2:0]` counts bit positions. A byte boundary is `ph == 7`, which wraps to 0.
- Comma counter `bc_cnt[3:0]` saturates at `BC_LOCK`.
- FSM states:
  - SEARCH, bit-sliding: on `match`, set `ph <= 0` and `bc_cnt <= 1`. Go to LOCKED if `BC_LOCK == 1`, otherwise go to ALIGN. With no match, `ph` is don't-care and held at 0.
  - ALIGN, aligned and confirming: `ph` increments each cycle. At a boundary:
    - `match`: increment `bc_cnt`. Go to LOCKED when the new count equals `BC_LOCK`.
    - non-match: go to SEARCH and clear `bc_cnt`.
    - Non-boundary matches are ignored.
  - LOCKED: `ph` keeps wrapping. At a boundary:
    - non-`IDLE` byte: `data_out <= sr` and `valid_out <= 1`.
    - `IDLE` byte: no strobe and `data_out` holds.
    - LOCKED is left only by reset, or by the relock feature (see Configuration).
- `valid_out` is 0 in every cycle that is not a LOCKED boundary with data.
- `active` is registered and equals `state == LOCKED`.

## Timing
- Reset values (asynchronous assert, synchronous release on the next `clk_8f`): `sr=0`, `ph=0`, `bc_cnt=0`, state SEARCH, `data_out=0`, `valid_out=0`, `active=0`. Because `sr` resets to 0, the first match needs 8 real bits.
- Latency: the last bit of a byte is captured into `sr` at edge t, and `data_out`/`valid_out` are registered at edge t+1.
- Lock timing: if the final confirming comma completes in `sr` at edge t, `active` rises at edge t+1. The first data byte strobes no earlier than t+9.
- Strobe spacing is exactly 8 cycles for back-to-back data bytes.
- Reset mid-byte or while LOCKED: all state clears immediately, and `valid_out` drops in the same instant with no partial byte emitted.
- Simultaneous events: if `match` coincides with a boundary in ALIGN, it counts as a comma. A boundary and lock-loss detection in the same cycle resolves to lock loss, with no strobe.

## Configuration
- `SERTOPAR_RELOCK_EN` defined:
  - In LOCKED, a `match` at `ph != 7` increments a misalign counter `mis_cnt[3:0]`.
  - An aligned boundary `IDLE` clears `mis_cnt`.
  - When `mis_cnt` reaches `BC_LOCK`, go to SEARCH and clear `active`, `bc_cnt` and `mis_cnt`. No strobe is emitted that cycle.
- `SERTOPAR_RELOCK_EN` undefined: no `mis_cnt` register, and LOCKED is exited only by reset.

## Structure
- Shared package `phy_pkg`:
  - FSM state encoding: SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2.
  - `IDLE_BYTE` constant 8'hBC, shared with the transmit serializer.
- Sub-module `comma_detect`: an 8-bit shift register plus `match` compare. The FSM and output registers stay in the top module.

## Test plan
- Reset: hold `reset_L=0` with random `data_in` -> `data_out=0`, `valid_out=0`, `active=0` throughout. After release, no `valid_out` until lock.
- Lock, aligned: stream 4×`0xBC` MSB-first starting at bit 0 -> `active` rises 1 cycle after the 4th comma completes. Then `0xA5`, `0x3C` -> `valid_out` pulses 8 cycles apart with `data_out=0xA5`, then `0x3C`.
- Lock, unaligned: prefix 3 random bits, then 4×`0xBC` and `0x5A` -> alignment is found, lock is reached, and exactly one strobe occurs with `data_out=0x5A`.
- Broken lock-up: `0xBC`, `0xBC`, `0x11`, then 4×`0xBC` -> return to SEARCH after `0x11` (so `0x11` produces no strobe), then lock after the later 4 commas.
- Idle filtering: when locked, send `0x77`, `0xBC`, `0xBC`, `0x88` -> 2 strobes, 24 cycles apart, and `data_out` holds `0x77` during the idles.
- Relock (`SERTOPAR_RELOCK_EN`): when locked, insert 1 bit of slip, then 4×`0xBC` -> `active` falls after the 4th misaligned comma, then relocks on the new phase after 4 more aligned commas. Without the macro, `active` stays 1.
